mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: idle cycles between request acceptance and response (range 0..15).
REQ-002 SHALL have parameter DEPTH_WORDS, default 64: number of 32-bit words in the array (power of two, 4..1024).
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, 1: controller requests a memory access.
REQ-006 SHALL have port we, input, 1: 1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr, input, 32: byte address, sampled with req.
REQ-008 SHALL have port wdata, input, 32: write data, sampled with req.
REQ-009 SHALL have port rdata, output, 32: read data, registered.
REQ-010 SHALL have port ack, output, 1: single-cycle completion strobe, registered.
REQ-011 SHALL have port busy, output, 1: high while a request is in flight and new requests are ignored.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-013 SHALL accept a request on a rising edge when req=1 and the state is IDLE or RESP; at that edge addr, we and wdata are latched.
REQ-014 On acceptance with WAIT_CYCLES>0, SHALL enter WAIT and load a down-counter with WAIT_CYCLES-1; with WAIT_CYCLES=0, SHALL go directly to RESP.
REQ-015 In WAIT, SHALL decrement the counter each edge and enter RESP on the edge where the counter is 0.
REQ-016 On the edge entering RESP, SHALL perform the access: write stores wdata at the word index; read loads rdata from it. Word index = addr[log2(DEPTH_WORDS)+1:2].
REQ-017 SHALL assert ack only in RESP, for exactly one cycle per accepted request; ack rises WAIT_CYCLES+1 edges after the accepting edge.
REQ-018 SHALL keep rdata unchanged until the next completed read; writes SHALL NOT alter rdata.
REQ-019 SHALL assert busy exactly when the state is WAIT; req while busy is ignored and not queued.
REQ-020 RESP with req=0 SHALL return to IDLE; RESP with req=1 SHALL accept back-to-back. A read immediately after a write to the same word SHALL return the new data.
REQ-021 Addresses beyond the array SHALL wrap via the index truncation; addr[1:0] SHALL be ignored (unless REQ-025 applies).

Reset
REQ-022 Reset low SHALL immediately force state IDLE, counter 0, ack 0, busy 0 and rdata 0x00000000.
REQ-023 Reset during WAIT SHALL discard the pending access: no write occurs and no ack is issued. Array contents SHALL NOT be reset.
REQ-024 After reset deasserts, the first accepting edge SHALL behave exactly as from IDLE.

Configuration
REQ-025 With macro MEM_RESPONDER_ERR_EN defined, SHALL add output err (1 bit, reset 0). err is asserted with ack when addr[1:0]!=0 or addr >= 4*DEPTH_WORDS. On such a request the write is suppressed and rdata is loaded with 0. Without the macro, the port is absent and REQ-021 applies.

Structure
REQ-026 SHALL place the FSM state encodings (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the counter width constant in the shared package mem_resp_pkg.
REQ-027 SHALL instantiate one sub-module, mem_resp_array: synchronous single-port word array with write enable, index in, data in and registered data out.

Verification
REQ-028 WAIT_CYCLES=2: write 0xDEADBEEF to 0x10, then read 0x10 -> ack 3 edges after each accept; rdata=0xDEADBEEF; busy high for 2 cycles per access.
REQ-029 WAIT_CYCLES=0: req held high for 4 consecutive reads of 0x0,0x4,0x8,0xC -> 4 acks on consecutive cycles; busy never high.
REQ-030 req pulsed while busy (WAIT_CYCLES=3) -> ignored; exactly one ack; latched addr unchanged.
REQ-031 Reset low mid-WAIT during a write of 0x12345678 to 0x20 -> no ack; later read of 0x20 returns the prior value; rdata=0 immediately after reset.
REQ-032 DEPTH_WORDS=64: write 0xA5A5A5A5 to 0x100 -> read of 0x000 returns 0xA5A5A5A5 (wrap).
REQ-033 MEM_RESPONDER_ERR_EN: write to 0x102, then read 0x400 -> err=1 with each ack; memory unmodified; rdata=0.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared constants for mem_responder: FSM encodings, wait-counter width and the
// address check used when MEM_RESPONDER_ERR_EN is defined.
package mem_resp_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  function automatic logic addr_bad(input logic [31:0] a, input int unsigned depth_words);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * depth_words));
  endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Synchronous single-port word array with write enable and registered read data.
module mem_resp_array #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IDX_W       = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      din,
  output logic [31:0]      dout
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= din;
    dout <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts a request, waits WAIT_CYCLES, performs the word access
// and strobes ack. Define MEM_RESPONDER_ERR_EN to add the err output.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy
`ifdef MEM_RESPONDER_ERR_EN
  ,
  output logic        err
`endif
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             accept, enter_resp;
  logic             lat_we;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;
  logic             acc_we, acc_bad, lat_bad;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_wdata;
  logic [31:0]      arr_dout;

  assign accept = req && ((state == IDLE) || (state == RESP));
  assign busy   = (state == WAIT);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(WAIT_CYCLES - 1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With no wait the access happens on the accepting edge, so it must use the live inputs.
  assign acc_idx   = (state == WAIT) ? lat_idx   : addr[IDX_W+1:2];
  assign acc_we    = (state == WAIT) ? lat_we    : we;
  assign acc_wdata = (state == WAIT) ? lat_wdata : wdata;

`ifdef MEM_RESPONDER_ERR_EN
  assign acc_bad = (state == WAIT) ? lat_bad : addr_bad(addr, DEPTH_WORDS);
`else
  logic unused_addr;
  assign unused_addr = ^{addr[31:IDX_W+2], addr[1:0], lat_bad};
  assign acc_bad     = 1'b0;
`endif

  mem_resp_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk (clk),
    .we  (enter_resp && acc_we && !acc_bad),
    .idx (acc_idx),
    .din (acc_wdata),
    .dout(arr_dout)
  );

  // The array output is registered, so completion (ack/rdata) lands one edge after RESP
  // is entered; the latched request still describes that access during RESP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      ack       <= 1'b0;
      rdata     <= '0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_bad   <= 1'b0;
`ifdef MEM_RESPONDER_ERR_EN
      err       <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack   <= (state == RESP);
      if (accept) begin
        lat_we    <= we;
        lat_idx   <= addr[IDX_W+1:2];
        lat_wdata <= wdata;
`ifdef MEM_RESPONDER_ERR_EN
        lat_bad   <= addr_bad(addr, DEPTH_WORDS);
`endif
      end
      if ((state == RESP) && !lat_we) rdata <= lat_bad ? '0 : arr_dout;
`ifdef MEM_RESPONDER_ERR_EN
      err <= (state == RESP) && lat_bad;
`endif
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances with WAIT_CYCLES 2, 0 and 3.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        busy  [3];
`ifdef MEM_RESPONDER_ERR_EN
  logic        err   [3];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .WAIT_CYCLES(g == 1 ? 0 : (g == 0 ? 2 : 3)),
      .DEPTH_WORDS(64)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .req  (req[g]),
      .we   (we[g]),
      .addr (addr[g]),
      .wdata(wdata[g]),
      .rdata(rdata[g]),
      .ack  (ack[g]),
      .busy (busy[g])
`ifdef MEM_RESPONDER_ERR_EN
      ,
      .err  (err[g])
`endif
    );
  end

  function automatic int wc(input int d);
    return (d == 1) ? 0 : ((d == 0) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One-cycle request pulse; returns edges from accept to ack (-1 on timeout) and busy cycles.
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      output int lat, output int nbusy);
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(negedge clk);
    req[d] = 1'b0;
    nbusy = busy[d] ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy[d]) nbusy++;
      if (ack[d]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic acc(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input string tag);
    int lat, nb;
    xfer(d, w, a, wd, lat, nb);
    chk({tag, "_lat"}, 32'(lat), 32'(wc(d) + 1));
    chk({tag, "_busy"}, 32'(nb), 32'(wc(d)));
  endtask

  initial begin
    logic [31:0] vals [4];
    int n;
    vals = '{32'h0000_1111, 32'h2222_0000, 32'h3333_4444, 32'h5555_6666};
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
    end

    #1 reset = 1'b0;
    #1;
    chk("rst_rdata", rdata[0], 32'h0);
    chk("rst_ack", 32'(ack[0]), 32'h0);
    chk("rst_busy", 32'(busy[2]), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // WAIT_CYCLES=2 write then read
    acc(0, 1'b1, 32'h10, 32'hDEAD_BEEF, "w2_wr");
    acc(0, 1'b0, 32'h10, 32'h0, "w2_rd");
    chk("w2_rdata", rdata[0], 32'hDEAD_BEEF);
    acc(0, 1'b1, 32'h14, 32'h0000_0055, "w2_wr2");
    chk("w2_rdata_kept", rdata[0], 32'hDEAD_BEEF);

    // WAIT_CYCLES=0 back-to-back reads
    for (int i = 0; i < 4; i++) acc(1, 1'b1, 32'(i * 4), vals[i], "w0_wr");
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(busy[1]), 32'h0);
      if (i >= 1 && i <= 4) begin
        chk("b2b_ack", 32'(ack[1]), 32'h1);
        chk("b2b_rdata", rdata[1], vals[i-1]);
      end else begin
        chk("b2b_noack", 32'(ack[1]), 32'h0);
      end
      if (i < 3) addr[1] = 32'((i + 1) * 4);
      else req[1] = 1'b0;
    end

    // write immediately followed by read of the same word
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h30; wdata[1] = 32'hC0FF_EE00;
    @(negedge clk);
    we[1] = 1'b0;
    @(negedge clk);
    req[1] = 1'b0;
    chk("raw_wr_ack", 32'(ack[1]), 32'h1);
    @(negedge clk);
    chk("raw_rd_ack", 32'(ack[1]), 32'h1);
    chk("raw_rdata", rdata[1], 32'hC0FF_EE00);

    // WAIT_CYCLES=3: request while busy is dropped
    acc(2, 1'b1, 32'h44, 32'h0BAD_F00D, "w3_wr");
    acc(2, 1'b1, 32'h48, 32'h600D_CAFE, "w3_wr2");
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h44;
    @(negedge clk);
    chk("w3_busy", 32'(busy[2]), 32'h1);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h48; wdata[2] = 32'hFFFF_FFFF;
    @(negedge clk);
    req[2] = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack[2]) n++;
    end
    chk("w3_ack_count", 32'(n), 32'h1);
    chk("w3_rdata", rdata[2], 32'h0BAD_F00D);
    acc(2, 1'b0, 32'h48, 32'h0, "w3_rd2");
    chk("w3_no_write", rdata[2], 32'h600D_CAFE);

    // reset in the middle of a pending write
    acc(0, 1'b1, 32'h20, 32'h1111_0000, "rs_wr");
    acc(0, 1'b0, 32'h20, 32'h0, "rs_rd");
    chk("rs_prior", rdata[0], 32'h1111_0000);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234_5678;
    @(negedge clk);
    req[0] = 1'b0;
    chk("rs_busy_pre", 32'(busy[0]), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rs_rdata0", rdata[0], 32'h0);
    chk("rs_busy0", 32'(busy[0]), 32'h0);
    chk("rs_ack0", 32'(ack[0]), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack[0]) n++;
    end
    chk("rs_no_ack", 32'(n), 32'h0);
    acc(0, 1'b0, 32'h20, 32'h0, "rs_rd2");
    chk("rs_kept", rdata[0], 32'h1111_0000);

`ifndef MEM_RESPONDER_ERR_EN
    // index wrap and ignored byte offset
    acc(0, 1'b1, 32'h100, 32'hA5A5_A5A5, "wr_wrap");
    acc(0, 1'b0, 32'h000, 32'h0, "rd_wrap");
    chk("wrap_rdata", rdata[0], 32'hA5A5_A5A5);
    acc(0, 1'b0, 32'h103, 32'h0, "rd_offs");
    chk("offs_rdata", rdata[0], 32'hA5A5_A5A5);
`else
    acc(0, 1'b1, 32'h000, 32'h0000_0077, "e_wr_ok");
    chk("e_ok_err", 32'(err[0]), 32'h0);
    acc(0, 1'b1, 32'h102, 32'h0000_0099, "e_wr_bad");
    chk("e_wr_err", 32'(err[0]), 32'h1);
    acc(0, 1'b0, 32'h000, 32'h0, "e_rd_ok");
    chk("e_rd_err", 32'(err[0]), 32'h0);
    chk("e_mem_kept", rdata[0], 32'h0000_0077);
    acc(0, 1'b0, 32'h400, 32'h0, "e_rd_bad");
    chk("e_rd_bad_err", 32'(err[0]), 32'h1);
    chk("e_rd_bad_data", rdata[0], 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
